sensor_conditioner: RTL and testbench

//   Front end for the traffic light controller's side-road car sensor. Synchronises and debounces
//   the raw detector, latches a car-waiting request and drives the controller's sns input.
//   The request is held until the controller acknowledges service (clr), then re-arms after a hold-off window.

---
 rtl/sensor_conditioner_if.sv | 27 ++
 rtl/sensor_conditioner.sv | 91 +++++++++
 tb/tb_sensor_conditioner.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sensor_conditioner_if.sv
// Side-road sensor bundle between detector, conditioner and light controller.
// The conditioner sits on the slave side; the bench or upstream logic is master.
interface sensor_conditioner_if #(
    parameter int CNT_W = 8
);
    logic             raw_sns;
    logic             clr;
    logic             sns;
    logic             car_present;
    logic [CNT_W-1:0] req_count;

    modport master (
        output raw_sns,
        output clr,
        input  sns,
        input  car_present,
        input  req_count
    );

    modport slave (
        input  raw_sns,
        input  clr,
        output sns,
        output car_present,
        output req_count
    );
endinterface

// File: rtl/sensor_conditioner.sv
// Side-road car sensor front end: synchronise, debounce, latch a request
// until the controller serves it, then hold off before re-arming.
module sensor_conditioner #(
    parameter int DEB_CYCLES  = 8,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 res,
    sensor_conditioner_if.slave  bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic [DW-1:0]    r_deb_cnt;
    logic             r_car;
    state_t           r_state;
    logic [HW-1:0]    r_hold_cnt;
    logic [CNT_W-1:0] r_req_cnt;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.raw_sns;
            r_sync2 <= r_sync1;
        end
    end

    // The level only moves after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_deb_cnt <= '0;
            r_car     <= 1'b0;
        end else if (r_sync2 == r_car) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_LAST) begin
            r_deb_cnt <= '0;
            r_car     <= r_sync2;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_req_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_car) begin
                        r_state <= ST_PEND;
                        if (r_req_cnt != {CNT_W{1'b1}})
                            r_req_cnt <= r_req_cnt + 1'b1;
                    end
                end
                ST_PEND: begin
                    if (bus.clr) begin
                        r_state    <= ST_HOLD;
                        r_hold_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sns         = (r_state == ST_PEND);
    assign bus.car_present = r_car;
    assign bus.req_count   = r_req_cnt;
endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with hand-derived cycle timing.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_sensor_conditioner;
    logic clk;
    logic res;
    int   n_checks;
    int   n_fail;
    int   exp_cnt;
    bit   got_sns;

    sensor_conditioner_if #(.CNT_W(8)) bus ();

    sensor_conditioner #(
        .DEB_CYCLES (8),
        .HOLD_CYCLES(16),
        .CNT_W      (8)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        res         = 1'b1;
        bus.raw_sns = 1'b0;
        bus.clr     = 1'b0;
        tick(3);
        check("rst_sns", bus.sns, 0);
        check("rst_car", bus.car_present, 0);
        check("rst_cnt", bus.req_count, 0);

        // clean press: raw rises before edge 1
        res         = 1'b0;
        bus.raw_sns = 1'b1;
        tick(9);
        check("car_e9", bus.car_present, 0);
        tick();
        check("car_e10", bus.car_present, 1);
        check("sns_e10", bus.sns, 0);
        tick();
        check("sns_e11", bus.sns, 1);
        check("cnt_e11", bus.req_count, 1);

        // serve, then hold-off with stray clr pulses and car still there
        tick();
        bus.clr = 1'b1;
        tick();
        check("sns_clrE", bus.sns, 0);
        for (int k = 1; k <= 16; k++) begin
            bus.clr = (k == 5 || k == 10);
            tick();
        end
        bus.clr = 1'b0;
        check("sns_E16", bus.sns, 0);
        tick();
        check("sns_E17", bus.sns, 1);
        check("cnt_E17", bus.req_count, 2);

        // async reset in the middle of a clock period while pending
        @(posedge clk);
        #2;
        res = 1'b1;
        #1;
        check("arst_sns", bus.sns, 0);
        check("arst_car", bus.car_present, 0);
        check("arst_cnt", bus.req_count, 0);
        bus.raw_sns = 1'b0;
        tick(2);
        res = 1'b0;
        tick(2);
        check("post_rst_sns", bus.sns, 0);

        // bouncing detector never settles long enough
        repeat (3) begin
            bus.raw_sns = 1'b1;
            tick(5);
            bus.raw_sns = 1'b0;
            tick(5);
        end
        tick(12);
        check("bnc_car", bus.car_present, 0);
        check("bnc_sns", bus.sns, 0);
        check("bnc_cnt", bus.req_count, 0);

        // clr in IDLE does nothing
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        tick();
        check("idle_clr_sns", bus.sns, 0);
        check("idle_clr_cnt", bus.req_count, 0);

        // clr arrives on the same edge the FSM sees car_present
        bus.raw_sns = 1'b1;
        tick(10);
        check("same_car", bus.car_present, 1);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check("same_sns", bus.sns, 1);
        check("same_cnt", bus.req_count, 1);

        // car leaving does not cancel a pending request
        bus.raw_sns = 1'b0;
        tick(12);
        check("leave_car", bus.car_present, 0);
        check("leave_sns", bus.sns, 1);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check("leave_clr", bus.sns, 0);
        tick(20);

        // saturation run
        exp_cnt = 1;
        for (int i = 0; i < 300; i++) begin
            bus.raw_sns = 1'b1;
            got_sns     = 1'b0;
            for (int w = 0; w < 40 && !got_sns; w++) begin
                tick();
                got_sns = bus.sns;
            end
            check("sat_rise", got_sns, 1);
            if (exp_cnt < 255) exp_cnt++;
            check("sat_cnt", bus.req_count, exp_cnt);
            bus.clr = 1'b1;
            tick();
            bus.clr     = 1'b0;
            bus.raw_sns = 1'b0;
            check("sat_fall", bus.sns, 0);
            tick(20);
        end
        check("sat_final", bus.req_count, 255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
